// File: rtl/fg_period_sequencer.sv
// Period sequencer for the function-generator datapath: prescaled tick, period counter,
// shadowed configuration applied at period boundaries, and continuous/burst run control.
module fg_period_sequencer #(
    parameter int COUNTER_BITWIDTH   = 32,
    parameter int PRESCALER_BITWIDTH = 16,
    parameter int BURST_BITWIDTH     = 16
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          start_i,
    input  logic                          stop_i,
    input  logic                          cfg_valid_i,
    output logic                          cfg_ready_o,
    input  logic [COUNTER_BITWIDTH-1:0]   cfg_period_i,
    input  logic [COUNTER_BITWIDTH-1:0]   cfg_on_time_i,
    input  logic [PRESCALER_BITWIDTH-1:0] cfg_prescaler_i,
    input  logic [BURST_BITWIDTH-1:0]     cfg_burst_i,
    output logic                          clk_en_o,
    output logic [COUNTER_BITWIDTH-1:0]   CR_o,
    output logic [COUNTER_BITWIDTH-1:0]   counter_o,
    output logic [COUNTER_BITWIDTH-1:0]   ON_counter_o,
    output logic                          busy_o,
    output logic                          period_done_o,
    output logic                          burst_done_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_e;

    state_e                        state_q, state_d;
    logic [PRESCALER_BITWIDTH-1:0] presc_cnt_q, presc_cnt_d;
    logic [COUNTER_BITWIDTH-1:0]   cr_q, cr_d;
    logic [COUNTER_BITWIDTH-1:0]   period_q, period_d;
    logic [COUNTER_BITWIDTH-1:0]   on_q, on_d;
    logic [PRESCALER_BITWIDTH-1:0] prescaler_q, prescaler_d;
    logic [BURST_BITWIDTH-1:0]     burst_q, burst_d;
    logic [BURST_BITWIDTH-1:0]     burst_target_q, burst_target_d;
    logic [BURST_BITWIDTH-1:0]     burst_cnt_q, burst_cnt_d;
    logic [COUNTER_BITWIDTH-1:0]   sh_period_q, sh_period_d;
    logic [COUNTER_BITWIDTH-1:0]   sh_on_q, sh_on_d;
    logic [PRESCALER_BITWIDTH-1:0] sh_presc_q, sh_presc_d;
    logic [BURST_BITWIDTH-1:0]     sh_burst_q, sh_burst_d;
    logic                          pending_q, pending_d;

    logic                          tick;
    logic                          wrap;
    logic                          cfg_fire;
    logic                          apply_shadow;
    logic                          burst_last;
    logic [COUNTER_BITWIDTH-1:0]   on_clamped;

    assign tick         = (state_q != IDLE) && (presc_cnt_q == prescaler_q);
    assign wrap         = tick && (cr_q == period_q);
    assign cfg_fire     = cfg_valid_i && !pending_q;
    assign apply_shadow = pending_q && ((state_q == IDLE) || wrap);
    assign burst_last   = (burst_target_q != '0) &&
                          (burst_cnt_q == burst_target_q - BURST_BITWIDTH'(1));
    assign on_clamped   = (cfg_on_time_i > cfg_period_i) ? cfg_period_i : cfg_on_time_i;

    always_comb begin
        state_d        = state_q;
        presc_cnt_d    = presc_cnt_q;
        cr_d           = cr_q;
        period_d       = period_q;
        on_d           = on_q;
        prescaler_d    = prescaler_q;
        burst_d        = burst_q;
        burst_target_d = burst_target_q;
        burst_cnt_d    = burst_cnt_q;
        sh_period_d    = sh_period_q;
        sh_on_d        = sh_on_q;
        sh_presc_d     = sh_presc_q;
        sh_burst_d     = sh_burst_q;
        pending_d      = pending_q;

        // Capture and apply are exclusive: capture needs an empty shadow, apply needs a full one.
        if (cfg_fire) begin
            sh_period_d = cfg_period_i;
            sh_on_d     = on_clamped;
            sh_presc_d  = cfg_prescaler_i;
            sh_burst_d  = cfg_burst_i;
            pending_d   = 1'b1;
        end

        if (apply_shadow) begin
            period_d    = sh_period_q;
            on_d        = sh_on_q;
            prescaler_d = sh_presc_q;
            burst_d     = sh_burst_q;
            pending_d   = 1'b0;
        end

        if (state_q != IDLE) begin
            presc_cnt_d = tick ? '0 : presc_cnt_q + PRESCALER_BITWIDTH'(1);
            if (tick) begin
                cr_d = wrap ? '0 : cr_q + COUNTER_BITWIDTH'(1);
            end
            if (wrap && (burst_cnt_q != '1)) begin
                burst_cnt_d = burst_cnt_q + BURST_BITWIDTH'(1);
            end
        end

        unique case (state_q)
            IDLE: begin
                presc_cnt_d = '0;
                cr_d        = '0;
                if (start_i && !stop_i) begin
                    state_d        = RUN;
                    burst_cnt_d    = '0;
                    // A shadow applied on this same edge also supplies the burst length.
                    burst_target_d = apply_shadow ? sh_burst_q : burst_q;
                end
            end
            RUN: begin
                if (wrap) begin
                    if (stop_i || burst_last) begin
                        state_d = IDLE;
                    end
                end else if (stop_i) begin
                    state_d = STOPPING;
                end
            end
            STOPPING: begin
                if (wrap) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q        <= IDLE;
            presc_cnt_q    <= '0;
            cr_q           <= '0;
            period_q       <= '0;
            on_q           <= '0;
            prescaler_q    <= '0;
            burst_q        <= '0;
            burst_target_q <= '0;
            burst_cnt_q    <= '0;
            sh_period_q    <= '0;
            sh_on_q        <= '0;
            sh_presc_q     <= '0;
            sh_burst_q     <= '0;
            pending_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            presc_cnt_q    <= presc_cnt_d;
            cr_q           <= cr_d;
            period_q       <= period_d;
            on_q           <= on_d;
            prescaler_q    <= prescaler_d;
            burst_q        <= burst_d;
            burst_target_q <= burst_target_d;
            burst_cnt_q    <= burst_cnt_d;
            sh_period_q    <= sh_period_d;
            sh_on_q        <= sh_on_d;
            sh_presc_q     <= sh_presc_d;
            sh_burst_q     <= sh_burst_d;
            pending_q      <= pending_d;
        end
    end

    assign cfg_ready_o   = !pending_q;
    assign clk_en_o      = tick;
    assign CR_o          = cr_q;
    assign counter_o     = period_q;
    assign ON_counter_o  = on_q;
    assign busy_o        = (state_q != IDLE);
    assign period_done_o = wrap;
    assign burst_done_o  = (state_q == RUN) && wrap && burst_last;

endmodule

// File: tb/tb_fg_period_sequencer.sv
// Scoreboard bench for fg_period_sequencer: stimulus queues the expected tick records,
// a negedge monitor pops and compares one record per clk_en_o pulse.
module tb_fg_period_sequencer;

    localparam int CW = 32;
    localparam int PW = 16;
    localparam int BW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          cfgValid = 1'b0;
    logic          cfgReady;
    logic [CW-1:0] cfgPeriod = '0;
    logic [CW-1:0] cfgOn = '0;
    logic [PW-1:0] cfgPresc = '0;
    logic [BW-1:0] cfgBurst = '0;
    logic          clkEn;
    logic [CW-1:0] crO;
    logic [CW-1:0] counterO;
    logic [CW-1:0] onO;
    logic          busy;
    logic          periodDone;
    logic          burstDone;

    fg_period_sequencer #(
        .COUNTER_BITWIDTH  (CW),
        .PRESCALER_BITWIDTH(PW),
        .BURST_BITWIDTH    (BW)
    ) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .start_i        (start),
        .stop_i         (stop),
        .cfg_valid_i    (cfgValid),
        .cfg_ready_o    (cfgReady),
        .cfg_period_i   (cfgPeriod),
        .cfg_on_time_i  (cfgOn),
        .cfg_prescaler_i(cfgPresc),
        .cfg_burst_i    (cfgBurst),
        .clk_en_o       (clkEn),
        .CR_o           (crO),
        .counter_o      (counterO),
        .ON_counter_o   (onO),
        .busy_o         (busy),
        .period_done_o  (periodDone),
        .burst_done_o   (burstDone)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] cr;
        logic [CW-1:0] cnt;
        logic [CW-1:0] on;
        logic          pd;
        logic          bd;
        int            gap;
    } tick_t;

    tick_t expQ[$];
    int    checks = 0;
    int    errors = 0;
    int    gap = 0;
    int    tickIdx = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every tick pops one expected record; gap counts busy clocks since the previous tick.
    always @(negedge clk) begin
        if (!rstn) begin
            gap = 0;
        end else begin
            if (busy) gap++;
            if (clkEn) begin
                if (expQ.size() == 0) begin
                    checkOutput($sformatf("unexpected_tick_cr%0d", crO), {63'd0, clkEn}, 64'd0);
                end else begin
                    tick_t e;
                    e = expQ.pop_front();
                    checkOutput($sformatf("tick%0d_cr", tickIdx), {32'd0, crO}, {32'd0, e.cr});
                    checkOutput($sformatf("tick%0d_counter", tickIdx), {32'd0, counterO}, {32'd0, e.cnt});
                    checkOutput($sformatf("tick%0d_on", tickIdx), {32'd0, onO}, {32'd0, e.on});
                    checkOutput($sformatf("tick%0d_period_done", tickIdx), {63'd0, periodDone}, {63'd0, e.pd});
                    checkOutput($sformatf("tick%0d_burst_done", tickIdx), {63'd0, burstDone}, {63'd0, e.bd});
                    checkOutput($sformatf("tick%0d_gap", tickIdx), 64'(gap), 64'(e.gap));
                end
                tickIdx++;
                gap = 0;
            end else if (!busy) begin
                gap = 0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pushTick(input int cr, input int cnt, input int on, input bit pd, input bit bd, input int g);
        tick_t t;
        t.cr = CW'(cr); t.cnt = CW'(cnt); t.on = CW'(on); t.pd = pd; t.bd = bd; t.gap = g;
        expQ.push_back(t);
    endtask

    // Push 'periods' full periods of ticks for a given active configuration.
    task automatic pushPeriods(input int periods, input int period, input int on, input int g);
        for (int p = 0; p < periods; p++)
            for (int c = 0; c <= period; c++)
                pushTick(c, period, on, (c == period), 1'b0, g);
    endtask

    // Load a configuration while IDLE and confirm the shadow handshake and copy.
    task automatic applyStimulus(input int period, input int on, input int presc, input int burst, input int expOn);
        int b = 0;
        step();
        while (!cfgReady && b < 50) begin step(); b++; end
        checkOutput("cfg_ready_idle", {63'd0, cfgReady}, 64'd1);
        cfgValid = 1'b1;
        cfgPeriod = CW'(period); cfgOn = CW'(on); cfgPresc = PW'(presc); cfgBurst = BW'(burst);
        step();
        cfgValid = 1'b0;
        checkOutput("ready_low_after_capture", {63'd0, cfgReady}, 64'd0);
        step();
        checkOutput("ready_after_copy", {63'd0, cfgReady}, 64'd1);
        checkOutput("counter_after_copy", {32'd0, counterO}, 64'(period));
        checkOutput("on_after_copy", {32'd0, onO}, 64'(expOn));
    endtask

    task automatic startRun();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulseStop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic waitRemaining(input int n, input string name);
        int b = 0;
        while (expQ.size() > n && b < 300) begin step(); b++; end
        checkOutput({name, "_ticks_seen"}, 64'(expQ.size()), 64'(n));
    endtask

    task automatic waitCr(input int v, input string name);
        int b = 0;
        while (crO != CW'(v) && b < 100) begin step(); b++; end
        checkOutput({name, "_cr_reached"}, {32'd0, crO}, 64'(v));
    endtask

    task automatic waitIdle(input string name);
        int b = 0;
        while (busy && b < 300) begin step(); b++; end
        checkOutput({name, "_idle"}, {63'd0, busy}, 64'd0);
        checkOutput({name, "_drained"}, 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        repeat (3) step();
        rstn = 1'b1;
        checkOutput("reset_cr", {32'd0, crO}, 64'd0);
        checkOutput("reset_counter", {32'd0, counterO}, 64'd0);
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_ready", {63'd0, cfgReady}, 64'd1);
        checkOutput("reset_clk_en", {63'd0, clkEn}, 64'd0);

        // Asynchronous reset in the middle of a run at CR=5.
        applyStimulus(9, 4, 0, 0, 4);
        for (int c = 0; c <= 5; c++) pushTick(c, 9, 4, 1'b0, 1'b0, 1);
        startRun();
        waitCr(5, "pre_reset");
        #2 rstn = 1'b0;
        #1;
        checkOutput("async_rst_cr", {32'd0, crO}, 64'd0);
        checkOutput("async_rst_counter", {32'd0, counterO}, 64'd0);
        checkOutput("async_rst_on", {32'd0, onO}, 64'd0);
        checkOutput("async_rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("async_rst_clk_en", {63'd0, clkEn}, 64'd0);
        checkOutput("async_rst_ready", {63'd0, cfgReady}, 64'd1);
        checkOutput("async_rst_pulses", {62'd0, periodDone, burstDone}, 64'd0);
        step();
        rstn = 1'b1;
        checkOutput("async_rst_drained", 64'(expQ.size()), 64'd0);

        // Continuous, prescaler 0: tick every clock, CR 0..3.
        applyStimulus(3, 1, 0, 0, 1);
        pushPeriods(3, 3, 1, 1);
        startRun();
        waitRemaining(3, "cont");
        pulseStop();
        waitIdle("cont");

        // Prescaler 2, period 1: tick every third clock.
        applyStimulus(1, 0, 2, 0, 0);
        pushPeriods(3, 1, 0, 3);
        startRun();
        waitRemaining(1, "presc");
        pulseStop();
        waitIdle("presc");

        // Burst of two periods of three ticks; burst_done on the final wrap.
        applyStimulus(2, 1, 0, 2, 1);
        for (int i = 0; i < 6; i++) pushTick(i % 3, 2, 1, (i % 3 == 2), (i == 5), 1);
        startRun();
        waitRemaining(0, "burst");
        checkOutput("burst_busy_last_tick", {63'd0, busy}, 64'd1);
        step();
        checkOutput("burst_busy_drop", {63'd0, busy}, 64'd0);

        // Reconfigure mid-period; new values (ON clamped to period) appear only after the wrap.
        applyStimulus(7, 3, 0, 0, 3);
        pushPeriods(1, 7, 3, 1);
        pushPeriods(2, 2, 2, 1);
        startRun();
        waitCr(3, "reconfig");
        cfgValid = 1'b1;
        cfgPeriod = CW'(2); cfgOn = CW'(9); cfgPresc = '0; cfgBurst = '0;
        step();
        cfgValid = 1'b0;
        checkOutput("reconfig_ready_low", {63'd0, cfgReady}, 64'd0);
        checkOutput("reconfig_counter_held", {32'd0, counterO}, 64'd7);
        waitCr(7, "reconfig_wrap");
        checkOutput("reconfig_ready_low_at_wrap", {63'd0, cfgReady}, 64'd0);
        step();
        checkOutput("reconfig_ready_after_wrap", {63'd0, cfgReady}, 64'd1);
        checkOutput("reconfig_counter_new", {32'd0, counterO}, 64'd2);
        checkOutput("reconfig_on_clamped", {32'd0, onO}, 64'd2);
        waitRemaining(2, "reconfig");
        pulseStop();
        waitIdle("reconfig");

        // Stop at CR=2 of a period-5 run: period completes, no burst_done.
        applyStimulus(5, 1, 0, 0, 1);
        pushPeriods(1, 5, 1, 1);
        startRun();
        waitRemaining(3, "stop");
        checkOutput("stop_cr_at_request", {32'd0, crO}, 64'd2);
        pulseStop();
        waitIdle("stop");

        // start and stop together while IDLE must not start a run.
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        checkOutput("start_stop_idle_0", {63'd0, busy}, 64'd0);
        step();
        checkOutput("start_stop_idle_1", {63'd0, busy}, 64'd0);
        checkOutput("start_stop_no_tick", {63'd0, clkEn}, 64'd0);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/fg_period_sequencer.md
Name: fg_period_sequencer

Overview:
- Controller that sequences the function-generator waveform datapath.
- Generates the prescaled clock enable and the period counter register (CR) consumed by the waveform generator.
- Holds the active period and ON-time configuration and applies new settings only at period boundaries.
- Supports continuous and burst (N-period) operation with start/stop control; sits between the register interface and the waveform generator.

Parameters:
- COUNTER_BITWIDTH, 32, width of period/ON-time/CR values
- PRESCALER_BITWIDTH, 16, width of clock-enable divider
- BURST_BITWIDTH, 16, width of burst period count

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- start_i  in  1  start request (level sampled each cycle)
- stop_i  in  1  stop request; finishes current period
- cfg_valid_i  in  1  new configuration offered
- cfg_ready_o  out  1  shadow register free; handshake completes when valid&ready
- cfg_period_i  in  COUNTER_BITWIDTH  last CR value of a period (period = value+1 ticks)
- cfg_on_time_i  in  COUNTER_BITWIDTH  CR value at which fall starts
- cfg_prescaler_i  in  PRESCALER_BITWIDTH  enable divider (tick every value+1 clocks)
- cfg_burst_i  in  BURST_BITWIDTH  periods per burst; 0 = continuous
- clk_en_o  out  1  tick to waveform datapath
- CR_o  out  COUNTER_BITWIDTH  counter register
- counter_o  out  COUNTER_BITWIDTH  active period value
- ON_counter_o  out  COUNTER_BITWIDTH  active ON value
- busy_o  out  1  state != IDLE
- period_done_o  out  1  one-cycle pulse at last tick of each period
- burst_done_o  out  1  one-cycle pulse when burst completes

Behaviour:
- Reset (async, rstn_i low): state IDLE; CR_o, counter_o, ON_counter_o, presc_cnt, burst count, shadow regs = 0; pending = 0; cfg_ready_o = 1; all pulses and clk_en_o = 0.
- Shadow load: on cfg_valid_i & cfg_ready_o, all cfg_* fields are captured and pending is set, so cfg_ready_o = 0.
  - On_time is clamped to period on capture.
- Active update:
  - In IDLE, a pending shadow is copied to the active registers on the next edge (pending cleared, cfg_ready_o = 1 next cycle).
  - In RUN/STOPPING, copy happens only on a wrap edge.
- States: IDLE, RUN, STOPPING.
  - IDLE -> RUN: start_i=1 and stop_i=0. presc_cnt := 0, CR_o := 0, burst count := 0, burst target := active cfg_burst.
  - start_i together with stop_i in IDLE: stay IDLE.
  - RUN -> STOPPING: stop_i=1 on a non-wrap cycle.
  - RUN -> IDLE on wrap if stop_i=1, or if burst target != 0 and burst count == target-1 (burst_done_o=1 that cycle, only for the burst case).
  - STOPPING -> IDLE on wrap; no burst_done_o.
  - start_i in RUN/STOPPING ignored.
- Tick: clk_en_o = (state != IDLE) & (presc_cnt == active prescaler), combinational from registers.
  - presc_cnt increments each cycle when not IDLE and clears to 0 on tick.
  - With prescaler 0, clk_en_o is high every cycle from the first cycle after start.
- CR: increments on tick edges. Wrap edge = tick & (CR_o == counter_o): CR_o := 0, burst count += 1 (saturating).
  - period_done_o = wrap condition (combinational, same cycle).
  - First tick after start presents CR_o = 0.
- In IDLE: CR_o held 0, clk_en_o 0.
- Period 0: every tick is a wrap; CR_o stays 0.
- Widths: all counters unsigned. No overflow beyond saturation on burst count.

Test Plan:
- Reset mid-RUN (CR_o=5): assert rstn_i low asynchronously -> all outputs 0 immediately, state IDLE, cfg_ready_o=1.
- cfg period=3, on=1, prescaler=0, burst=0; start -> CR_o sequence 0,1,2,3,0,1… with clk_en_o constant 1; period_done_o pulses every 4 cycles.
- prescaler=2, period=1 -> clk_en_o high every 3rd clock; CR_o changes only on those edges; period_done_o every 6 clocks.
- burst=2, period=2, prescaler=0 -> exactly 6 ticks, then IDLE; burst_done_o one pulse coincident with the second period_done_o; busy_o drops next cycle.
- Mid-period reconfig:
  - Running period=7, load period=2, on=9 at CR=3 -> counter_o stays 7 until wrap, then counter_o=2, ON_counter_o=2 (clamped).
  - cfg_ready_o stays low from capture until wrap.
- stop_i at CR=2 (period=5) -> continues to CR=5, wrap, then IDLE with no burst_done_o.
  - Separately, start_i & stop_i together in IDLE -> remains IDLE.
